// File: rtl/memory_arbiter_pkg.sv
// Shared types for the L1-miss memory arbiter: bus packet layout, FSM states
// and requester identity.
package memory_arbiter_pkg;

    typedef struct packed {
        logic        source;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } BusPacket;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RETURN    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INSN = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the shared memory port.
// slave = arbiter side, master = caches/memory side.
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic     insn_req_valid;
    BusPacket insn_req_pkt;
    logic     insn_req_ack;
    logic     data_req_valid;
    BusPacket data_req_pkt;
    logic     data_req_ack;
    logic     mem_req_valid;
    BusPacket mem_req_pkt;
    logic     mem_req_ready;
    logic     mem_resp_valid;
    BusPacket mem_resp_pkt;
    logic     mem_resp_ack;
    logic     insn_resp_valid;
    BusPacket insn_resp_pkt;
    logic     insn_resp_ready;
    logic     data_resp_valid;
    BusPacket data_resp_pkt;
    logic     data_resp_ready;
    logic     timeout_err;

    modport slave (
        input  insn_req_valid, insn_req_pkt, data_req_valid, data_req_pkt,
        input  mem_req_ready, mem_resp_valid, mem_resp_pkt,
        input  insn_resp_ready, data_resp_ready,
        output insn_req_ack, data_req_ack, mem_req_valid, mem_req_pkt, mem_resp_ack,
        output insn_resp_valid, insn_resp_pkt, data_resp_valid, data_resp_pkt,
        output timeout_err
    );

    modport master (
        output insn_req_valid, insn_req_pkt, data_req_valid, data_req_pkt,
        output mem_req_ready, mem_resp_valid, mem_resp_pkt,
        output insn_resp_ready, data_resp_ready,
        input  insn_req_ack, data_req_ack, mem_req_valid, mem_req_pkt, mem_resp_ack,
        input  insn_resp_valid, insn_resp_pkt, data_resp_valid, data_resp_pkt,
        input  timeout_err
    );

endinterface

// File: rtl/memory_arbiter_rr.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to whichever requester was not granted last.
module rr_arbiter2
    import memory_arbiter_pkg::*;
(
    input  logic   req_insn_i,
    input  logic   req_data_i,
    input  owner_t last_grant_i,
    output logic   grant_vld_o,
    output owner_t winner_o
);

    always_comb begin
        grant_vld_o = req_insn_i | req_data_i;
        winner_o    = OWN_INSN;
        if (req_insn_i && req_data_i) begin
            winner_o = (last_grant_i == OWN_INSN) ? OWN_DATA : OWN_INSN;
        end else if (req_data_i) begin
            winner_o = OWN_DATA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Single-outstanding arbiter between the L1 instruction and data caches and a
// shared memory bus, with a bounded wait for the memory response.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic             clk,
    input  logic             reset,
    memory_arbiter_if.slave  bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    BusPacket         req_pkt_q, req_pkt_d;
    BusPacket         resp_pkt_q, resp_pkt_d;
    logic             grant_vld;
    owner_t           winner;

    rr_arbiter2 u_rr (
        .req_insn_i   (bus.insn_req_valid),
        .req_data_i   (bus.data_req_valid),
        .last_grant_i (last_grant_q),
        .grant_vld_o  (grant_vld),
        .winner_o     (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_INSN;
            last_grant_q <= OWN_DATA;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Packet holding registers carry no reset; outputs are gated by state.
    always_ff @(posedge clk) begin
        req_pkt_q  <= req_pkt_d;
        resp_pkt_q <= resp_pkt_d;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        req_pkt_d    = req_pkt_q;
        resp_pkt_d   = resp_pkt_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    req_pkt_d    = (winner == OWN_INSN) ? bus.insn_req_pkt : bus.data_req_pkt;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response in the final wait cycle still wins over the timeout.
                if (bus.mem_resp_valid) begin
                    resp_pkt_d = bus.mem_resp_pkt;
                    state_d    = RETURN;
                end else if (cnt_q >= CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RETURN: begin
                if ((owner_q == OWN_INSN) ? bus.insn_resp_ready : bus.data_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.insn_req_ack    = 1'b0;
        bus.data_req_ack    = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_pkt     = '0;
        bus.mem_resp_ack    = 1'b0;
        bus.insn_resp_valid = 1'b0;
        bus.insn_resp_pkt   = '0;
        bus.data_resp_valid = 1'b0;
        bus.data_resp_pkt   = '0;
        bus.timeout_err     = timeout_q;
        case (state_q)
            IDLE: begin
                if (!reset && grant_vld) begin
                    bus.insn_req_ack = (winner == OWN_INSN);
                    bus.data_req_ack = (winner == OWN_DATA);
                end
            end
            ISSUE: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_pkt   = req_pkt_q;
            end
            WAIT_RESP: bus.mem_resp_ack = 1'b1;
            RETURN: begin
                if (owner_q == OWN_INSN) begin
                    bus.insn_resp_valid = 1'b1;
                    bus.insn_resp_pkt   = resp_pkt_q;
                end else begin
                    bus.data_resp_valid = 1'b1;
                    bus.data_resp_pkt   = resp_pkt_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed transaction table, corner-case sequences
// and a randomized run against a transaction-level scoreboard.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int TO = 16;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    memory_arbiter_if bus ();

    memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic report(input bit ok, input string name, input string act, input string exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        report(act === exp, name, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        report(act === exp, name, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic chkp(input string name, input BusPacket act, input BusPacket exp);
        report(act === exp, name, $sformatf("%h", act), $sformatf("%h", exp));
    endtask

    task automatic chki(input string name, input int act, input int exp);
        report(act == exp, name, $sformatf("%0d", act), $sformatf("%0d", exp));
    endtask

    function automatic BusPacket rand_pkt();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return BusPacket'(r[$bits(BusPacket)-1:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.insn_req_valid  = 1'b0;
        bus.insn_req_pkt    = '0;
        bus.data_req_valid  = 1'b0;
        bus.data_req_pkt    = '0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_resp_valid  = 1'b0;
        bus.mem_resp_pkt    = '0;
        bus.insn_resp_ready = 1'b0;
        bus.data_resp_ready = 1'b0;
    endtask

    // One complete transaction from IDLE; called at posedge+1, returns at posedge+1 in IDLE.
    task automatic do_txn(input logic iv, input logic dv, input logic exp_i, input logic exp_d,
                          input int lat, input int hold, input string tag);
        BusPacket pi, pd, win, rp;
        pi = rand_pkt();
        pd = rand_pkt();
        rp = rand_pkt();
        rp.source = exp_i;  // deliberately points at the non-owner
        bus.insn_req_valid = iv;
        bus.insn_req_pkt   = pi;
        bus.data_req_valid = dv;
        bus.data_req_pkt   = pd;
        #1;
        chk1({tag, "_insn_ack"}, bus.insn_req_ack, exp_i);
        chk1({tag, "_data_ack"}, bus.data_req_ack, exp_d);
        chk1({tag, "_mreq_early"}, bus.mem_req_valid, 1'b0);
        win = exp_i ? pi : pd;
        tick();
        bus.insn_req_valid = 1'b0;
        bus.data_req_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        #1;
        chk1({tag, "_mreq_valid"}, bus.mem_req_valid, 1'b1);
        chkp({tag, "_mreq_pkt"}, bus.mem_req_pkt, win);
        tick();
        bus.mem_req_ready = 1'b0;
        repeat (lat) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_pkt   = rp;
        #1;
        chk1({tag, "_mresp_ack"}, bus.mem_resp_ack, 1'b1);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_pkt   = '0;
        for (int k = 0; k < hold; k++) begin
            bus.insn_req_valid = 1'b1;
            bus.data_req_valid = 1'b1;
            #1;
            chk1({tag, "_hold_valid"}, exp_i ? bus.insn_resp_valid : bus.data_resp_valid, 1'b1);
            chkp({tag, "_hold_pkt"}, exp_i ? bus.insn_resp_pkt : bus.data_resp_pkt, rp);
            chk2({tag, "_hold_noack"}, {bus.insn_req_ack, bus.data_req_ack}, 2'b00);
            tick();
        end
        bus.insn_req_valid  = 1'b0;
        bus.data_req_valid  = 1'b0;
        bus.insn_resp_ready = 1'b1;
        bus.data_resp_ready = 1'b1;
        #1;
        chk1({tag, "_insn_resp_v"}, bus.insn_resp_valid, exp_i);
        chk1({tag, "_data_resp_v"}, bus.data_resp_valid, exp_d);
        chkp({tag, "_resp_pkt"}, exp_i ? bus.insn_resp_pkt : bus.data_resp_pkt, rp);
        tick();
        bus.insn_resp_ready = 1'b0;
        bus.data_resp_ready = 1'b0;
    endtask

    typedef struct {
        logic iv;
        logic dv;
        logic exp_i;
        logic exp_d;
    } vec_t;

    vec_t tbl[8];

    // Randomized-run scoreboard state
    logic     ip, dp, last_w, outst, sent, waiting, returning, own;
    logic     ea_i, ea_d, ir, dr;
    BusPacket ipk, dpk, exp_req, exp_resp, rp;
    int       lat, grants, done;

    initial begin
        BusPacket tp;
        int c;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.insn_req_valid = 1'b1;
        bus.data_req_valid = 1'b1;
        bus.insn_req_pkt   = rand_pkt();
        bus.data_req_pkt   = rand_pkt();
        bus.mem_resp_valid = 1'b1;
        #1;
        chk2("rst_acks", {bus.insn_req_ack, bus.data_req_ack}, 2'b00);
        chk1("rst_mreq_v", bus.mem_req_valid, 1'b0);
        chkp("rst_mreq_pkt", bus.mem_req_pkt, '0);
        chk1("rst_mresp_ack", bus.mem_resp_ack, 1'b0);
        chk2("rst_resp_v", {bus.insn_resp_valid, bus.data_resp_valid}, 2'b00);
        chkp("rst_iresp_pkt", bus.insn_resp_pkt, '0);
        chkp("rst_dresp_pkt", bus.data_resp_pkt, '0);
        chk1("rst_timeout", bus.timeout_err, 1'b0);
        idle_inputs();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].iv, tbl[i].dv, tbl[i].exp_i, tbl[i].exp_d, i % 4, 0, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 3; i++) do_txn(1'b0, 1'b1, 1'b0, 1'b1, 5, 0, $sformatf("b2b%0d", i));

        do_txn(1'b1, 1'b0, 1'b1, 1'b0, 2, 10, "hold");

        // Response pulsed while the request is still being issued
        bus.insn_req_valid = 1'b1;
        bus.insn_req_pkt   = rand_pkt();
        #1;
        chk1("early_ack", bus.insn_req_ack, 1'b1);
        tick();
        bus.insn_req_valid = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_pkt   = rand_pkt();
        #1;
        chk1("early_mreq_v", bus.mem_req_valid, 1'b1);
        chk1("early_mresp_ack", bus.mem_resp_ack, 1'b0);
        chk2("early_resp_v", {bus.insn_resp_valid, bus.data_resp_valid}, 2'b00);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        #1;
        chk1("early_mreq_v2", bus.mem_req_valid, 1'b1);
        tick();
        bus.mem_req_ready  = 1'b0;
        tp = rand_pkt();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_pkt   = tp;
        #1;
        chk1("early_mresp_ack2", bus.mem_resp_ack, 1'b1);
        tick();
        bus.mem_resp_valid  = 1'b0;
        bus.insn_resp_ready = 1'b1;
        #1;
        chk1("early_resp_v2", bus.insn_resp_valid, 1'b1);
        chkp("early_resp_pkt", bus.insn_resp_pkt, tp);
        tick();
        bus.insn_resp_ready = 1'b0;

        // Memory never answers
        bus.insn_req_valid = 1'b1;
        bus.insn_req_pkt   = rand_pkt();
        #1;
        chk1("to_ack", bus.insn_req_ack, 1'b1);
        tick();
        bus.insn_req_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        c = 0;
        #1;
        while (bus.timeout_err !== 1'b1 && c < 40) begin
            tick();
            c++;
            #1;
        end
        chki("to_latency", c, TO);
        chk1("to_idle_mreq", bus.mem_req_valid, 1'b0);
        chk1("to_idle_mresp_ack", bus.mem_resp_ack, 1'b0);
        tick();
        do_txn(1'b1, 1'b1, 1'b0, 1'b1, 1, 0, "post_to");
        #1;
        chk1("to_sticky", bus.timeout_err, 1'b1);
        tick();

        // Reset while waiting for memory
        bus.insn_req_valid = 1'b1;
        bus.insn_req_pkt   = rand_pkt();
        #1;
        chk1("rw_ack", bus.insn_req_ack, 1'b1);
        tick();
        bus.insn_req_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk1("rw_mresp_ack", bus.mem_resp_ack, 1'b0);
        chk1("rw_timeout_clr", bus.timeout_err, 1'b0);
        chk1("rw_mreq_v", bus.mem_req_valid, 1'b0);
        tick();
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_pkt   = rand_pkt();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk2("rw_no_resp", {bus.insn_resp_valid, bus.data_resp_valid}, 2'b00);
            chk1("rw_no_consume", bus.mem_resp_ack, 1'b0);
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        do_txn(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, "post_rst");

        // Randomized run against the scoreboard
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ip = 0; dp = 0; last_w = 1'b1; outst = 0; sent = 0; waiting = 0; returning = 0; own = 0;
        ipk = '0; dpk = '0; exp_req = '0; exp_resp = '0; rp = '0;
        lat = 0; grants = 0; done = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin ip = 1'b1; ipk = rand_pkt(); end
            if (!dp && $urandom_range(0, 2) == 0) begin dp = 1'b1; dpk = rand_pkt(); end
            bus.insn_req_valid = ip;
            bus.insn_req_pkt   = ipk;
            bus.data_req_valid = dp;
            bus.data_req_pkt   = dpk;
            bus.mem_req_ready  = ($urandom_range(0, 1) == 1);
            if (waiting) begin
                bus.mem_resp_valid = (lat == 0);
                if (lat == 0) rp = rand_pkt();
                bus.mem_resp_pkt = rp;
            end else begin
                bus.mem_resp_valid = ($urandom_range(0, 3) == 0);
                bus.mem_resp_pkt   = rand_pkt();
            end
            ir = ($urandom_range(0, 1) == 1);
            dr = ($urandom_range(0, 1) == 1);
            bus.insn_resp_ready = ir;
            bus.data_resp_ready = dr;
            #1;
            ea_i = 1'b0;
            ea_d = 1'b0;
            if (!outst) begin
                if (ip && dp) begin
                    ea_i = last_w;
                    ea_d = !last_w;
                end else begin
                    ea_i = ip;
                    ea_d = dp;
                end
            end
            chk2("rnd_acks", {bus.insn_req_ack, bus.data_req_ack}, {ea_i, ea_d});
            chk1("rnd_mreq_v", bus.mem_req_valid, outst && !sent);
            if (outst && !sent) chkp("rnd_mreq_pkt", bus.mem_req_pkt, exp_req);
            chk1("rnd_mresp_ack", bus.mem_resp_ack, waiting);
            chk2("rnd_resp_v", {bus.insn_resp_valid, bus.data_resp_valid},
                 {returning && !own, returning && own});
            if (returning) chkp("rnd_resp_pkt", own ? bus.data_resp_pkt : bus.insn_resp_pkt, exp_resp);
            if (returning) begin
                if (own ? dr : ir) begin
                    returning = 1'b0;
                    outst     = 1'b0;
                    done++;
                end
            end else if (waiting) begin
                if (lat == 0) begin
                    waiting   = 1'b0;
                    returning = 1'b1;
                    exp_resp  = rp;
                end else begin
                    lat--;
                end
            end else if (outst && !sent && bus.mem_req_ready) begin
                sent    = 1'b1;
                waiting = 1'b1;
                lat     = $urandom_range(0, 8);
            end
            if (ea_i || ea_d) begin
                outst   = 1'b1;
                sent    = 1'b0;
                own     = ea_d;
                last_w  = ea_d;
                exp_req = ea_i ? ipk : dpk;
                grants++;
                if (ea_i) ip = 1'b0;
                else      dp = 1'b0;
            end
            tick();
        end
        chk1("rnd_progress", done >= 50, 1'b1);
        chki("rnd_grants_vs_done", grants - done, outst ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
